// File: rtl/hls_ctrl_pkg.sv
// Shared constants and state types for the HLS-style AXI4-Lite control slave.
// Offsets are byte addresses; the block decodes them as 8-byte words.
package hls_ctrl_pkg;

   localparam int unsigned CTRL_OFF = 'h00;
   localparam int unsigned GIE_OFF  = 'h08;
   localparam int unsigned IER_OFF  = 'h10;
   localparam int unsigned ISR_OFF  = 'h18;
   localparam int unsigned ARG_BASE = 'h20;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_DONE  = 1;
   localparam int unsigned CTRL_IDLE  = 2;
   localparam int unsigned CTRL_READY = 3;
   localparam int unsigned CTRL_AUTO  = 7;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WIDLE = 2'd0,
      WDATA = 2'd1,
      WRESP = 2'd2
   } wr_state_t;

   typedef enum logic {
      RIDLE = 1'b0,
      RDATA = 1'b1
   } rd_state_t;

   function automatic int unsigned word_of(input int unsigned off);
      return off >> 3;
   endfunction

endpackage

// File: rtl/hls_ctrl_slave.sv
// AXI4-Lite control-register slave that makes hand-written RTL look like an
// HLS kernel: block-level handshake, interrupt registers and 64-bit arguments.
module hls_ctrl_slave
   import hls_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int NUM_ARGS = 4
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic                   s_axi_control_AWVALID,
   output logic                   s_axi_control_AWREADY,
   input  logic [ADDR_W-1:0]      s_axi_control_AWADDR,
   input  logic                   s_axi_control_WVALID,
   output logic                   s_axi_control_WREADY,
   input  logic [63:0]            s_axi_control_WDATA,
   input  logic [7:0]             s_axi_control_WSTRB,
   output logic                   s_axi_control_BVALID,
   input  logic                   s_axi_control_BREADY,
   output logic [1:0]             s_axi_control_BRESP,
   input  logic                   s_axi_control_ARVALID,
   output logic                   s_axi_control_ARREADY,
   input  logic [ADDR_W-1:0]      s_axi_control_ARADDR,
   output logic                   s_axi_control_RVALID,
   input  logic                   s_axi_control_RREADY,
   output logic [63:0]            s_axi_control_RDATA,
   output logic [1:0]             s_axi_control_RRESP,
   output logic                   ap_start,
   input  logic                   ap_done,
   input  logic                   ap_idle,
   input  logic                   ap_ready,
   output logic [NUM_ARGS*64-1:0] args,
   output logic                   interrupt
);

   localparam int IDX_W = ADDR_W - 3;
   localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(word_of(CTRL_OFF));
   localparam logic [IDX_W-1:0] GIE_IDX  = IDX_W'(word_of(GIE_OFF));
   localparam logic [IDX_W-1:0] IER_IDX  = IDX_W'(word_of(IER_OFF));
   localparam logic [IDX_W-1:0] ISR_IDX  = IDX_W'(word_of(ISR_OFF));
   localparam logic [IDX_W-1:0] ARG_IDX  = IDX_W'(word_of(ARG_BASE));
   localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(word_of(ARG_BASE) + NUM_ARGS);

   wr_state_t wstate, wstate_nxt;
   rd_state_t rstate, rstate_nxt;

   logic             aw_fire, w_fire, ar_fire;
   logic [IDX_W-1:0] aw_idx, ar_idx;
   logic [1:0]       bresp_q, rresp_q;
   logic [63:0]      rdata_q, rd_mux;

   logic       ap_start_q, auto_restart, done_st, ready_st, idle_st;
   logic       gie, interrupt_q;
   logic [1:0] ier, isr, isr_wmask;
   logic       wsel_ctrl, wsel_gie, wsel_ier, wsel_isr, rd_ctrl;

   logic [NUM_ARGS*64-1:0] arg_flat;

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{s_axi_control_AWADDR[2:0], s_axi_control_ARADDR[2:0]};

   // ---------------- write channel FSM ----------------
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) wstate <= WIDLE;
      else           wstate <= wstate_nxt;
   end

   always_comb begin
      wstate_nxt            = wstate;
      s_axi_control_AWREADY = 1'b0;
      s_axi_control_WREADY  = 1'b0;
      s_axi_control_BVALID  = 1'b0;
      aw_fire               = 1'b0;
      w_fire                = 1'b0;
      case (wstate)
         WIDLE: begin
            s_axi_control_AWREADY = 1'b1;
            if (s_axi_control_AWVALID) begin
               aw_fire    = 1'b1;
               wstate_nxt = WDATA;
            end
         end
         WDATA: begin
            s_axi_control_WREADY = 1'b1;
            if (s_axi_control_WVALID) begin
               w_fire     = 1'b1;
               wstate_nxt = WRESP;
            end
         end
         WRESP: begin
            s_axi_control_BVALID = 1'b1;
            if (s_axi_control_BREADY) wstate_nxt = WIDLE;
         end
         default: wstate_nxt = WIDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         aw_idx  <= '0;
         bresp_q <= RESP_OKAY;
      end else begin
         if (aw_fire) aw_idx <= s_axi_control_AWADDR[ADDR_W-1:3];
         if (w_fire)  bresp_q <= (aw_idx < END_IDX) ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign s_axi_control_BRESP = bresp_q;

   // ---------------- read channel FSM ----------------
   assign ar_idx = s_axi_control_ARADDR[ADDR_W-1:3];

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) rstate <= RIDLE;
      else           rstate <= rstate_nxt;
   end

   always_comb begin
      rstate_nxt            = rstate;
      s_axi_control_ARREADY = 1'b0;
      s_axi_control_RVALID  = 1'b0;
      ar_fire               = 1'b0;
      case (rstate)
         RIDLE: begin
            s_axi_control_ARREADY = 1'b1;
            if (s_axi_control_ARVALID) begin
               ar_fire    = 1'b1;
               rstate_nxt = RDATA;
            end
         end
         RDATA: begin
            s_axi_control_RVALID = 1'b1;
            if (s_axi_control_RREADY) rstate_nxt = RIDLE;
         end
         default: rstate_nxt = RIDLE;
      endcase
   end

   // Unmapped offsets fall through with zero data.
   always_comb begin
      rd_mux = '0;
      if (ar_idx == CTRL_IDX)
         rd_mux = {56'd0, auto_restart, 3'd0, ready_st, idle_st, done_st, ap_start_q};
      else if (ar_idx == GIE_IDX)
         rd_mux = {63'd0, gie};
      else if (ar_idx == IER_IDX)
         rd_mux = {62'd0, ier};
      else if (ar_idx == ISR_IDX)
         rd_mux = {62'd0, isr};
      else begin
         for (int i = 0; i < NUM_ARGS; i++)
            if (ar_idx == IDX_W'(ARG_IDX + i)) rd_mux = arg_flat[64*i +: 64];
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_fire) begin
         rdata_q <= rd_mux;
         rresp_q <= (ar_idx < END_IDX) ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign s_axi_control_RDATA = rdata_q;
   assign s_axi_control_RRESP = rresp_q;

   // ---------------- control / interrupt registers ----------------
   assign wsel_ctrl = w_fire && s_axi_control_WSTRB[0] && (aw_idx == CTRL_IDX);
   assign wsel_gie  = w_fire && s_axi_control_WSTRB[0] && (aw_idx == GIE_IDX);
   assign wsel_ier  = w_fire && s_axi_control_WSTRB[0] && (aw_idx == IER_IDX);
   assign wsel_isr  = w_fire && s_axi_control_WSTRB[0] && (aw_idx == ISR_IDX);
   assign rd_ctrl   = ar_fire && (ar_idx == CTRL_IDX);
   assign isr_wmask = wsel_isr ? s_axi_control_WDATA[1:0] : 2'b00;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         ap_start_q   <= 1'b0;
         auto_restart <= 1'b0;
         done_st      <= 1'b0;
         ready_st     <= 1'b0;
         idle_st      <= 1'b0;
         gie          <= 1'b0;
         ier          <= 2'b00;
         isr          <= 2'b00;
         interrupt_q  <= 1'b0;
      end else begin
         if (wsel_ctrl) auto_restart <= s_axi_control_WDATA[CTRL_AUTO];
         // A software start takes priority over the kernel consuming the previous one.
         if (wsel_ctrl && s_axi_control_WDATA[CTRL_START]) ap_start_q <= 1'b1;
         else if (ap_ready && !auto_restart)               ap_start_q <= 1'b0;
         // Clear-on-read status; a same-cycle event keeps the bit set.
         done_st  <= ap_done  | (done_st  & ~rd_ctrl);
         ready_st <= ap_ready | (ready_st & ~rd_ctrl);
         idle_st  <= ap_idle;
         if (wsel_gie) gie <= s_axi_control_WDATA[0];
         if (wsel_ier) ier <= s_axi_control_WDATA[1:0];
         isr         <= (isr ^ isr_wmask) | {ap_ready & ier[1], ap_done & ier[0]};
         interrupt_q <= gie & (|isr);
      end
   end

   assign ap_start  = ap_start_q;
   assign interrupt = interrupt_q;

   // ---------------- argument registers ----------------
   for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_arg
      logic [63:0] q;
      logic        sel;
      assign sel = w_fire && (aw_idx == IDX_W'(ARG_IDX + gi));
      always_ff @(posedge ap_clk) begin
         if (!ap_rst_n) q <= '0;
         else if (sel) begin
            for (int b = 0; b < 8; b++)
               if (s_axi_control_WSTRB[b]) q[8*b +: 8] <= s_axi_control_WDATA[8*b +: 8];
         end
      end
      assign arg_flat[64*gi +: 64] = q;
   end

   assign args = arg_flat;

endmodule

// File: tb/tb_hls_ctrl_slave.sv
// Directed bench for hls_ctrl_slave: response queues are filled when a request
// is issued and drained when the slave answers.
module tb_hls_ctrl_slave;

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] ERR = 2'b10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  awaddr, araddr;
   logic [63:0]  wdata, rdata;
   logic [7:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic         ap_start, ap_done, ap_idle, ap_ready, interrupt;
   logic [255:0] args;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0]  bq[$];
   logic [63:0] rq_d[$];
   logic [1:0]  rq_r[$];

   hls_ctrl_slave #(.ADDR_W(32), .NUM_ARGS(4)) dut (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready),
      .s_axi_control_AWADDR(awaddr),
      .s_axi_control_WVALID(wvalid), .s_axi_control_WREADY(wready),
      .s_axi_control_WDATA(wdata), .s_axi_control_WSTRB(wstrb),
      .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready),
      .s_axi_control_BRESP(bresp),
      .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready),
      .s_axi_control_ARADDR(araddr),
      .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready),
      .s_axi_control_RDATA(rdata), .s_axi_control_RRESP(rresp),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .args(args), .interrupt(interrupt)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                     input logic [1:0] er, input int hold = 0, input logic rdy = 1'b0);
      logic [1:0] e;
      bq.push_back(er);
      @(negedge clk);
      awvalid = 1'b1; awaddr = a;
      chk("aw_ready", awready, 1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b1; wdata = d; wstrb = s; ap_ready = rdy;
      chk("w_ready", wready, 1);
      @(negedge clk);
      wvalid = 1'b0; ap_ready = 1'b0;
      chk("b_latency", bvalid, 1);
      repeat (hold) begin
         @(negedge clk);
         chk("b_hold", {bvalid, bresp}, {1'b1, bq[0]});
      end
      bready = 1'b1;
      e = bq.pop_front();
      chk("bresp", bresp, e);
      @(negedge clk);
      bready = 1'b0;
      chk("b_done", bvalid, 0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [63:0] ed, input logic [1:0] er,
                     input int hold = 0, input logic done = 1'b0);
      logic [63:0] xd;
      logic [1:0]  xr;
      rq_d.push_back(ed);
      rq_r.push_back(er);
      @(negedge clk);
      arvalid = 1'b1; araddr = a; ap_done = done;
      chk("ar_ready", arready, 1);
      @(negedge clk);
      arvalid = 1'b0; ap_done = 1'b0;
      chk("r_latency", rvalid, 1);
      repeat (hold) begin
         @(negedge clk);
         chk("r_hold", {rvalid, rresp, rdata}, {1'b1, rq_r[0], rq_d[0]});
      end
      rready = 1'b1;
      xd = rq_d.pop_front();
      xr = rq_r.pop_front();
      chk("rdata", rdata, xd);
      chk("rresp", rresp, xr);
      @(negedge clk);
      rready = 1'b0;
      chk("r_done", rvalid, 0);
   endtask

   task automatic pulse_ready();
      @(negedge clk); ap_ready = 1'b1;
      @(negedge clk); ap_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
      arvalid = 0; araddr = '0; rready = 0;
      ap_done = 0; ap_idle = 0; ap_ready = 0;
      repeat (3) @(negedge clk);
      chk("rst_hs", {awready, wready, bvalid, arready, rvalid, ap_start, interrupt}, 7'b1001000);
      chk("rst_args", args, 0);
      chk("rst_resp", {bresp, rresp, rdata}, 0);
      rst_n = 1'b1;

      // byte-masked argument writes
      wr(32'h28, 64'hDEADBEEF_01234567, 8'h0F, OK);
      rd(32'h28, 64'h00000000_01234567, OK);
      chk("arg1_port", args[127:64], 64'h00000000_01234567);
      wr(32'h28, 64'hAABBCCDD_EEFF0011, 8'hF0, OK);
      rd(32'h2C, 64'hAABBCCDD_01234567, OK);
      wr(32'h38, 64'h11223344_55667788, 8'hFF, OK);
      chk("arg3_port", args[255:192], 64'h11223344_55667788);
      chk("arg0_port", args[63:0], 0);

      // CTRL strobe gating and start/ready/done handshake
      wr(32'h00, 64'h1, 8'hFE, OK);
      chk("start_nostrb", ap_start, 0);
      wr(32'h00, 64'h1, 8'h01, OK);
      chk("start_set", ap_start, 1);
      @(negedge clk); ap_ready = 1'b1;
      chk("start_at_ready", ap_start, 1);
      @(negedge clk); ap_ready = 1'b0;
      chk("start_clr", ap_start, 0);
      @(negedge clk); ap_done = 1'b1;
      @(negedge clk); ap_done = 1'b0;
      rd(32'h00, 64'h0A, OK);
      rd(32'h00, 64'h00, OK);

      // auto_restart keeps start high; start write coinciding with ready wins
      wr(32'h00, 64'h81, 8'h01, OK);
      pulse_ready();
      chk("auto_r1", ap_start, 1);
      pulse_ready();
      chk("auto_r2", ap_start, 1);
      wr(32'h00, 64'h00, 8'h01, OK);
      chk("sw_noclr", ap_start, 1);
      pulse_ready();
      chk("auto_off", ap_start, 0);
      wr(32'h00, 64'h01, 8'h01, OK, 0, 1'b1);
      chk("start_vs_ready", ap_start, 1);
      pulse_ready();
      chk("start_clr2", ap_start, 0);
      ap_idle = 1'b1;
      rd(32'h00, 64'h0C, OK);
      ap_idle = 1'b0;
      rd(32'h00, 64'h00, OK, 0, 1'b1);
      rd(32'h00, 64'h02, OK);

      // interrupt path
      wr(32'h08, 64'h1, 8'h01, OK);
      wr(32'h10, 64'h1, 8'h01, OK);
      @(negedge clk); ap_done = 1'b1;
      @(negedge clk); ap_done = 1'b0;
      chk("irq_lag", interrupt, 0);
      @(negedge clk);
      chk("irq_set", interrupt, 1);
      rd(32'h18, 64'h1, OK);
      wr(32'h18, 64'h1, 8'h01, OK);
      chk("irq_clr", interrupt, 0);
      pulse_ready();
      rd(32'h18, 64'h0, OK);
      rd(32'h00, 64'h0A, OK);
      wr(32'h18, 64'h2, 8'h01, OK);
      chk("isr_toggle_irq", interrupt, 1);
      rd(32'h18, 64'h2, OK);
      wr(32'h18, 64'h2, 8'h01, OK);
      wr(32'h08, 64'h0, 8'h01, OK);
      rd(32'h10, 64'h1, OK);

      // unmapped offsets
      rd(32'h200, 64'h0, ERR);
      rd(32'h40, 64'h0, ERR);
      wr(32'h200, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, ERR);
      wr(32'h40, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, ERR);
      chk("unmapped_args", args,
          {64'h11223344_55667788, 64'h0, 64'hAABBCCDD_01234567, 64'h0});
      rd(32'h08, 64'h0, OK);
      rd(32'h18, 64'h0, OK);

      // back-pressure on B and R
      wr(32'h30, 64'h5555AAAA_5555AAAA, 8'hFF, OK, 10);
      rd(32'h30, 64'h5555AAAA_5555AAAA, OK, 10);
      wr(32'h200, 64'h0, 8'hFF, ERR, 10);

      // reset in the middle of a write
      wr(32'h00, 64'h1, 8'h01, OK);
      chk("pre_rst_start", ap_start, 1);
      @(negedge clk);
      awvalid = 1'b1; awaddr = 32'h28;
      @(negedge clk);
      awvalid = 1'b0;
      chk("mid_wdata", wready, 1);
      rst_n = 1'b0; wvalid = 1'b1; wdata = 64'hFFFFFFFF_FFFFFFFF; wstrb = 8'hFF;
      @(negedge clk);
      wvalid = 1'b0;
      chk("mid_rst_hs", {awready, wready, bvalid, arready, rvalid, ap_start, interrupt}, 7'b1001000);
      chk("mid_rst_args", args, 0);
      chk("mid_rst_resp", {bresp, rresp, rdata}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_stray_b", bvalid, 0);
      rd(32'h28, 64'h0, OK);
      rd(32'h00, 64'h0, OK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
